// File: rtl/jc_pkg.sv
// Shared encodings and seed helper for the jc_bidir_param pattern generator.
package jc_pkg;

  typedef enum logic [1:0] {
    DIR_STALL = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_e;

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'd0,
    MODE_RING    = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  localparam int SEED_MAX_W = 64;

  // Ring needs a single hot bit to circulate; every other mode starts empty.
  function automatic logic [SEED_MAX_W-1:0] jc_seed(input logic [1:0] mode);
    logic [SEED_MAX_W-1:0] s;
    s = '0;
    s[0] = (mode == MODE_RING);
    return s;
  endfunction

endpackage

// File: rtl/jc_prescaler.sv
// Free-running step-rate prescaler; tick fires when the count reaches div.
module jc_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // >= rather than == so lowering div below the running count wraps at once.
  always_comb begin
    tick  = (cnt_q >= div);
    cnt_d = cnt_q + DIV_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jc_bidir_param.sv
// Bidirectional Johnson / ring / bounce pattern generator with step prescaler.
//   dir       | meaning
//   DIR_STALL | pattern frozen, no step pulses
//   DIR_LEFT  | shift toward the MSB on each tick
//   DIR_RIGHT | shift toward the LSB on each tick
module jc_bidir_param
  import jc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             goLeft,
  input  logic             goRight,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       dir,
  output logic             step
);

  logic [WIDTH-1:0] q_q, q_d;
  dir_e             dir_q, dir_d;
  logic             step_q, step_d;
  logic [1:0]       mode_q, mode_d;

  logic             tick;
  logic             mode_chg;
  logic [WIDTH-1:0] seed_v;
  logic             btn_act;
  dir_e             btn_dir;
  logic             auto_rev;
  dir_e             shift_dir;
  logic             is_ring;
  logic             is_bounce;
  logic             take_step;

  assign mode_chg = (mode != mode_q);

  jc_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .div  (div),
    .clr  (mode_chg),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= seed_v;
      dir_q  <= DIR_STALL;
      step_q <= 1'b0;
      mode_q <= mode;
    end else begin
      q_q    <= q_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  always_comb begin
    seed_v    = WIDTH'(jc_seed(mode));
    is_ring   = (mode_q == MODE_RING);
    is_bounce = (mode_q == MODE_BOUNCE);

    btn_act = 1'b1;
    btn_dir = DIR_STALL;
    if (!stop) begin
      btn_dir = DIR_STALL;
    end else if (!goLeft) begin
      btn_dir = DIR_LEFT;
    end else if (!goRight) begin
      btn_dir = DIR_RIGHT;
    end else begin
      btn_act = 1'b0;
    end

    auto_rev  = 1'b0;
    shift_dir = dir_q;
    if (is_bounce && (dir_q == DIR_LEFT) && (&q_q)) begin
      auto_rev  = 1'b1;
      shift_dir = DIR_RIGHT;
    end else if (is_bounce && (dir_q == DIR_RIGHT) && !(|q_q)) begin
      auto_rev  = 1'b1;
      shift_dir = DIR_LEFT;
    end

    // A stop pressed on the very edge a bounce would reverse freezes the bar.
    take_step = !mode_chg && tick && (dir_q != DIR_STALL)
                && !(auto_rev && btn_act && (btn_dir == DIR_STALL));

    q_d    = q_q;
    step_d = 1'b0;
    mode_d = mode_q;
    if (mode_chg) begin
      q_d    = seed_v;
      mode_d = mode;
    end else if (take_step) begin
      step_d = 1'b1;
      if (shift_dir == DIR_LEFT) begin
        q_d = is_ring ? {q_q[WIDTH-2:0], q_q[WIDTH-1]}
                      : {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      end else begin
        q_d = is_ring ? {q_q[0], q_q[WIDTH-1:1]}
                      : {~q_q[0], q_q[WIDTH-1:1]};
      end
    end

    dir_d = dir_q;
    if (btn_act) begin
      dir_d = btn_dir;
    end else if (take_step && auto_rev) begin
      dir_d = shift_dir;
    end
  end

  always_comb begin
    q    = q_q;
    dir  = dir_q;
    step = step_q;
  end

endmodule

// File: tb/tb_jc_bidir_param.sv
// Directed bench for jc_bidir_param (WIDTH=4): per-cycle vector table plus corner sequences.
module tb_jc_bidir_param;

  localparam int W  = 4;
  localparam int DW = 24;

  typedef struct {
    logic          rst;
    logic          stop;
    logic          gl;
    logic          gr;
    logic [1:0]    mode;
    logic [DW-1:0] div;
    logic [W-1:0]  eq;
    logic [1:0]    edir;
    logic          estep;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, stop, goLeft, goRight;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [W-1:0]  q;
  logic [1:0]    dir;
  logic          step;

  int errors = 0;
  int checks = 0;
  vec_t vecs[$];

  jc_bidir_param #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .stop    (stop),
    .goLeft  (goLeft),
    .goRight (goRight),
    .mode    (mode),
    .div     (div),
    .q       (q),
    .dir     (dir),
    .step    (step)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq,
                         input logic [1:0] ed, input logic es);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".dir"}, 32'(dir), 32'(ed));
    chk({tag, ".step"}, 32'(step), 32'(es));
  endtask

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic s, input logic l, input logic g,
                     input logic [1:0] m, input logic [DW-1:0] d,
                     input logic [W-1:0] eq, input logic [1:0] ed, input logic es);
    vec_t v;
    v.rst = r; v.stop = s; v.gl = l; v.gr = g; v.mode = m; v.div = d;
    v.eq = eq; v.edir = ed; v.estep = es;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] ring_seq [4];
    bit exp_step;

    rst = 1'b1; stop = 1'b1; goLeft = 1'b1; goRight = 1'b1; mode = 2'd0; div = '0;

    // reset, then Johnson left run over a full 8-state cycle
    add(1,1,1,1, 0, 0, 4'b0000, 0, 0);
    add(0,1,0,1, 0, 0, 4'b0000, 1, 0);
    add(0,1,1,1, 0, 0, 4'b0001, 1, 1);
    add(0,1,1,1, 0, 0, 4'b0011, 1, 1);
    add(0,1,1,1, 0, 0, 4'b0111, 1, 1);
    add(0,1,1,1, 0, 0, 4'b1111, 1, 1);
    add(0,1,1,1, 0, 0, 4'b1110, 1, 1);
    add(0,1,1,1, 0, 0, 4'b1100, 1, 1);
    add(0,1,1,1, 0, 0, 4'b1000, 1, 1);
    add(0,1,1,1, 0, 0, 4'b0000, 1, 1);
    // direction change lands one step late
    add(0,1,1,1, 0, 0, 4'b0001, 1, 1);
    add(0,1,1,1, 0, 0, 4'b0011, 1, 1);
    add(0,1,1,1, 0, 0, 4'b0111, 1, 1);
    add(0,1,1,0, 0, 0, 4'b1111, 2, 1);
    add(0,1,1,1, 0, 0, 4'b0111, 2, 1);
    add(0,1,1,1, 0, 0, 4'b0011, 2, 1);
    add(0,1,1,1, 0, 0, 4'b0001, 2, 1);
    add(0,1,1,1, 0, 0, 4'b0000, 2, 1);
    add(0,1,1,1, 0, 0, 4'b1000, 2, 1);
    // bounce: mode change seeds zero, then auto-reverse at both ends
    add(0,1,0,1, 2, 0, 4'b0000, 1, 0);
    add(0,1,1,1, 2, 0, 4'b0001, 1, 1);
    add(0,1,1,1, 2, 0, 4'b0011, 1, 1);
    add(0,1,1,1, 2, 0, 4'b0111, 1, 1);
    add(0,1,1,1, 2, 0, 4'b1111, 1, 1);
    add(0,1,1,1, 2, 0, 4'b0111, 2, 1);
    add(0,1,1,1, 2, 0, 4'b0011, 2, 1);
    add(0,1,1,1, 2, 0, 4'b0001, 2, 1);
    add(0,1,1,1, 2, 0, 4'b0000, 2, 1);
    add(0,1,1,1, 2, 0, 4'b0001, 1, 1);
    // stop outranks both buttons; the edge it lands on still steps with old dir
    add(0,0,0,0, 2, 0, 4'b0011, 0, 1);
    add(0,0,0,0, 2, 0, 4'b0011, 0, 0);
    add(0,0,0,0, 2, 0, 4'b0011, 0, 0);
    add(0,1,1,0, 2, 0, 4'b0011, 2, 0);
    add(0,1,1,1, 2, 0, 4'b0001, 2, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; stop = vecs[i].stop; goLeft = vecs[i].gl;
      goRight = vecs[i].gr; mode = vecs[i].mode; div = vecs[i].div;
      clk_edge();
      chk_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].edir, vecs[i].estep);
    end

    // ring at div=2: a step every third clock
    ring_seq[0] = 4'b0010; ring_seq[1] = 4'b0100;
    ring_seq[2] = 4'b1000; ring_seq[3] = 4'b0001;
    mode = 2'd1; div = 24'd2; goLeft = 1'b0;
    clk_edge();
    chk_all("ring_seed", 4'b0001, 1, 0);
    goLeft = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      clk_edge();
      exp_step = (k % 3 == 0);
      chk($sformatf("ring_step%0d", k), 32'(step), 32'(exp_step));
      if (exp_step) chk($sformatf("ring_q%0d", k), 32'(q), 32'(ring_seq[k/3-1]));
    end

    // lowering div below the running count wraps on the next edge
    mode = 2'd0; div = 24'd10; goLeft = 1'b0;
    clk_edge();
    chk_all("div_seed", 4'b0000, 1, 0);
    goLeft = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      clk_edge();
      chk($sformatf("div_wait%0d", k), 32'(step), 32'(0));
    end
    div = 24'd3;
    clk_edge();
    chk_all("div_lower", 4'b0001, 1, 1);

    // mode change mid-pattern reseeds with no step
    div = '0;
    clk_edge();
    chk_all("pre_mc1", 4'b0011, 1, 1);
    clk_edge();
    chk_all("pre_mc2", 4'b0111, 1, 1);
    mode = 2'd1;
    clk_edge();
    chk_all("mode_chg", 4'b0001, 1, 0);
    clk_edge();
    chk_all("ring_run", 4'b0010, 1, 1);

    // reset mid-run, then ring seed under reset
    rst = 1'b1; mode = 2'd0;
    clk_edge();
    chk_all("rst_mid", 4'b0000, 0, 0);
    rst = 1'b0;
    clk_edge();
    chk_all("post_rst", 4'b0000, 0, 0);
    rst = 1'b1; mode = 2'd1;
    clk_edge();
    chk_all("rst_ring", 4'b0001, 0, 0);
    rst = 1'b0;
    clk_edge();
    chk_all("ring_idle", 4'b0001, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jc_bidir_param.md
Name: jc_bidir_param

Overview:
Parametrised bidirectional shift-pattern generator, successor of the fixed 4-bit Johnson counter.
- Generalised in width. Adds a run-time step-rate prescaler and three pattern modes: Johnson, ring and bounce (auto-reversing Johnson bar graph).
- Sits between the debounced board buttons and the LED bank.
- Direction is commanded by active-low stop/goLeft/goRight inputs, with the same priority as the previous generation.

Parameters:
WIDTH, 4, pattern width in bits; legal range is WIDTH >= 2.
DIV_W, 24, width of the prescaler divisor input and its internal counter.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous reset, active-high
stop  input  1  active-low; 0 = halt (highest priority)
goLeft  input  1  active-low; 0 = shift left
goRight  input  1  active-low; 0 = shift right
mode  input  2  0 = Johnson, 1 = ring, 2 = bounce, 3 = reserved (handled as Johnson)
div  input  DIV_W  step period minus one, in clk cycles
q  output  WIDTH  pattern output, registered
dir  output  2  current direction: STALL = 0, LEFT = 1, RIGHT = 2
step  output  1  one-cycle pulse on each cycle where a pattern step is taken

Behaviour:
- Reset: one clock, synchronous, active-high.
  - Sets q = seed(mode), dir = STALL, cnt = 0, step = 0, mode_q = mode.
  - seed is all-zeros for Johnson/bounce/reserved, and 0...01 for ring.
  - Reset mid-operation discards any pattern and direction in the same edge.
- Prescaler:
  - Free-running cnt. If cnt >= div, then cnt <= 0 and step_int = 1; otherwise cnt <= cnt + 1.
  - div = 0 gives a step every clk.
  - If div is lowered below the current cnt, the next edge wraps (comparison is >=, never ==).
  - step is registered: it is asserted in the cycle in which q shows the new value.
- Direction register (updated every clk, independent of step):
  - Priority is stop==0 -> STALL, else goLeft==0 -> LEFT, else goRight==0 -> RIGHT, else auto-reverse (bounce only), else hold.
  - A button-driven dir change takes effect on the next step; the current step uses dir from before the edge.
- Pattern update on step_int, using dir before the edge:
  - Johnson LEFT: q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
  - Johnson RIGHT: q <= {~q[0], q[WIDTH-1:1]}.
  - Ring LEFT: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - Ring RIGHT: q <= {q[0], q[WIDTH-1:1]}.
  - STALL: q holds, and step stays 0.
- Bounce mode (Johnson shifts with auto-reverse):
  - On step with dir LEFT and q all-ones: dir <= RIGHT and q takes the RIGHT shift in the same edge (1111 -> 0111).
  - On step with dir RIGHT and q all-zeros: dir <= LEFT and q takes the LEFT shift (0000 -> 0001).
  - A simultaneous active button overrides the auto-reverse dir value. q still takes the reversed shift on that edge, unless the button is stop, in which case q holds.
- Mode change (mode != mode_q):
  - q <= seed(mode), mode_q <= mode, cnt <= 0.
  - Step is suppressed that cycle; dir is retained.
- Sequence lengths: Johnson cycles through 2*WIDTH states and ring through WIDTH states. Both return exactly to the start value.

Decomposition:
- Package jc_pkg holds:
  - dir encodings STALL/LEFT/RIGHT;
  - mode encodings JOHNSON/RING/BOUNCE;
  - the seed function (mode, WIDTH).
- Sub-module jc_prescaler (params DIV_W; ports clk, rst, div, clr, tick) holds cnt and the wrap logic.
- Direction priority, mode tracking and the shifter stay in jc_bidir_param.

Test Plan:
1. WIDTH=4, mode=0, div=0, goLeft=0 pulse after reset -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 on consecutive steps, with step high every cycle.
2. Same setup, then goRight=0 at q=0111 -> one more left step to 1111 (dir not yet applied), then 0111, 0011, 0001, 0000, 1000.
3. mode=1, div=2, goLeft=0 -> q 0001 -> 0010 -> 0100 -> 1000 -> 0001, with exactly 3 clk between step pulses.
4. mode=2, div=0, goLeft=0 once -> q 0001, 0011, 0111, 1111, 0111, 0011, 0001, 0000, 0001; dir flips to 2 at 1111 and back to 1 at 0000.
5. Priority and stop: stop=0 with goLeft=0 and goRight=0 together -> dir=0, q frozen and step=0. Releasing stop while goRight=0 -> dir=2 after one edge.
6. Boundaries:
   - div changed from 10 to 3 while cnt=7 -> step on the next edge.
   - mode 0 -> 1 while at q=0111 -> q=0001 on the next edge with no step.
   - rst asserted mid-run -> q=0000, dir=0, step=0 on the next edge.
